// File: rtl/logic_function_pipe.sv
// Two-stage valid/ready pipeline that reduces (A&B) and NTERMS masked-XOR terms with a per-transaction op.
// Define LOGIC_FN_ACC_EN to add the acc_clr input and the ACC running-OR accumulator output.
module logic_function_pipe #(
    parameter int WIDTH  = 8,
    parameter int NTERMS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         A,
    input  logic [WIDTH-1:0]         B,
    input  logic [NTERMS*WIDTH-1:0]  C,
    input  logic [NTERMS*WIDTH-1:0]  D,
    input  logic [NTERMS*WIDTH-1:0]  E,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         Y
`ifdef LOGIC_FN_ACC_EN
    ,
    input  logic                     acc_clr,
    output logic [WIDTH-1:0]         ACC
`endif
);

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // A stage may load when it is empty or when its content leaves this cycle.
    logic adv1;
    logic adv2;
    logic s1_valid;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    logic [NTERMS:0][WIDTH-1:0] terms;

    always_comb begin
        terms    = '0;
        terms[0] = A & B;
        for (int i = 0; i < NTERMS; i++) begin
            terms[i+1] = (C[i*WIDTH +: WIDTH] ^ D[i*WIDTH +: WIDTH]) & E[i*WIDTH +: WIDTH];
        end
    end

    logic [NTERMS:0][WIDTH-1:0] s1_terms;
    logic [1:0]                 s1_op;

    // Payload registers only capture on a real transfer so idle inputs never disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_terms <= '0;
            s1_op    <= 2'b00;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_terms <= terms;
                s1_op    <= op;
            end
        end
    end

    logic [WIDTH-1:0] red_or;
    logic [WIDTH-1:0] red_and;
    logic [WIDTH-1:0] red_xor;
    logic [WIDTH-1:0] reduced;

    always_comb begin
        red_or  = '0;
        red_and = '1;
        red_xor = '0;
        for (int i = 0; i <= NTERMS; i++) begin
            red_or  = red_or  | s1_terms[i];
            red_and = red_and & s1_terms[i];
            red_xor = red_xor ^ s1_terms[i];
        end
    end

    always_comb begin
        reduced = red_or;
        case (s1_op)
            OP_OR:   reduced = red_or;
            OP_AND:  reduced = red_and;
            OP_XOR:  reduced = red_xor;
            OP_NOR:  reduced = ~red_or;
            default: reduced = red_or;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Y         <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Y <= reduced;
            end
        end
    end

`ifdef LOGIC_FN_ACC_EN
    logic out_xfer;
    assign out_xfer = out_valid && out_ready;

    // A clear coinciding with a delivery keeps only the value being delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ACC <= '0;
        end else if (out_xfer) begin
            ACC <= acc_clr ? Y : (ACC | Y);
        end else if (acc_clr) begin
            ACC <= '0;
        end
    end
`endif

endmodule
